// File: rtl/polyt0_pack_stream.sv
// Streaming t0 packer: biases each signed coefficient to 2^(D-1)-a and packs D-bit fields LSB-first into 32-bit words.
// Optional RANGE_CHECK_EN adds a sticky err flag for coefficients whose biased value does not fit in D bits.
module polyt0_pack_stream #(
   parameter int unsigned N = 256,
   parameter int unsigned D = 13
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        in_valid,
   input  logic [31:0] in_data,
   output logic        in_ready,
   output logic        out_valid,
   output logic [31:0] out_data,
   input  logic        out_ready,
   output logic        busy,
   output logic        done,
   output logic        err
);

   localparam int unsigned ACC_W  = 32 + D - 1;  // fill never exceeds 31 + D
   localparam int unsigned FILL_W = $clog2(ACC_W + 1);
   localparam int unsigned WORDS  = (N * D) / 32;
   localparam int unsigned CNT_W  = $clog2(N + 1);
   localparam int unsigned WCNT_W = $clog2(WORDS + 1);
   localparam logic [31:0] BIAS   = 32'(1) << (D - 1);

   typedef enum logic {IDLE, PACK} state_t;

   state_t              state_q, state_d;
   logic [CNT_W-1:0]    coef_q, coef_d;
   logic [WCNT_W-1:0]   word_q, word_d;
   logic [ACC_W-1:0]    acc_q, acc_d;
   logic [FILL_W-1:0]   fill_q, fill_d;
   logic                done_q, done_d;
   logic [31:0]         t_c;
   logic                in_hs_c, out_hs_c;

   assign t_c       = BIAS - in_data;
   assign in_ready  = (state_q == PACK) && (coef_q < CNT_W'(N)) && (fill_q < FILL_W'(32));
   assign out_valid = (state_q == PACK) && (fill_q >= FILL_W'(32));
   assign out_data  = acc_q[31:0];
   assign busy      = (state_q == PACK);
   assign done      = done_q;
   assign in_hs_c   = in_valid && in_ready;
   assign out_hs_c  = out_valid && out_ready;

`ifdef RANGE_CHECK_EN
   logic err_q, err_d;
   assign err = err_q;
`else
   logic unused_t_hi;
   assign unused_t_hi = ^t_c[31:D];
   assign err         = 1'b0;
`endif

   // Next-state and datapath update
   always_comb begin
      state_d = state_q;
      coef_d  = coef_q;
      word_d  = word_q;
      acc_d   = acc_q;
      fill_d  = fill_q;
      done_d  = 1'b0;
`ifdef RANGE_CHECK_EN
      err_d   = err_q;
`endif
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d = PACK;
               coef_d  = '0;
               word_d  = '0;
               acc_d   = '0;
               fill_d  = '0;
`ifdef RANGE_CHECK_EN
               err_d   = 1'b0;
`endif
            end
         end
         PACK: begin
            if (in_hs_c) begin
               acc_d  = acc_q | (ACC_W'(t_c[D-1:0]) << fill_q);
               fill_d = fill_q + FILL_W'(D);
               coef_d = coef_q + CNT_W'(1);
`ifdef RANGE_CHECK_EN
               if (t_c[31:D] != '0) err_d = 1'b1;
`endif
            end
            if (out_hs_c) begin
               acc_d  = acc_q >> 32;
               fill_d = fill_q - FILL_W'(32);
               word_d = word_q + WCNT_W'(1);
               if (word_q == WCNT_W'(WORDS - 1)) begin
                  state_d = IDLE;
                  done_d  = 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         coef_q  <= '0;
         word_q  <= '0;
         acc_q   <= '0;
         fill_q  <= '0;
         done_q  <= 1'b0;
`ifdef RANGE_CHECK_EN
         err_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         coef_q  <= coef_d;
         word_q  <= word_d;
         acc_q   <= acc_d;
         fill_q  <= fill_d;
         done_q  <= done_d;
`ifdef RANGE_CHECK_EN
         err_q   <= err_d;
`endif
      end
   end

endmodule

// File: tb/tb_polyt0_pack_stream.sv
// Directed bench for polyt0_pack_stream: bit-stream reference model plus hand-derived word constants.
module tb_polyt0_pack_stream;

   localparam int N     = 256;
   localparam int D     = 13;
   localparam int WORDS = (N * D) / 32;

   logic        clk = 1'b0;
   logic        rst, start, in_valid, out_ready;
   logic [31:0] in_data;
   logic        in_ready, out_valid, busy, done, err;
   logic [31:0] out_data;

   polyt0_pack_stream #(.N(N), .D(D)) dut (
      .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
      .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data),
      .out_ready(out_ready), .busy(busy), .done(done), .err(err)
   );

   always #5 clk = ~clk;

   int            n_cmp = 0;
   int            n_err = 0;
   logic [31:0]   coefs [N];
   logic [31:0]   got [WORDS];
   logic [N*D-1:0] exp_bits;
   int            n_done;
   logic          err_model;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_cmp++;
      assert (obs === expv) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, expv);
      end
   endtask

   task automatic build_expected();
      logic [31:0] t;
      for (int k = 0; k < N; k++) begin
         t = 32'd4096 - coefs[k];
         for (int b = 0; b < D; b++) exp_bits[k*D+b] = t[b];
      end
   endtask

   task automatic fill_coefs(input logic [31:0] v);
      for (int k = 0; k < N; k++) coefs[k] = v;
   endtask

   task automatic check_idle_reset();
      check("rst_in_ready", 32'(in_ready), 32'd0);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_out_data", out_data, 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_err", 32'(err), 32'd0);
   endtask

   // Runs one polynomial; abort_after >= 0 stops feeding after that many coefficients.
   task automatic run_poly(input int stall_word, input int stall_cyc, input int abort_after);
      int ci = 0, wi = 0, cyc = 0, hs0 = -1, first_ov = -1, stall_left = stall_cyc;
      logic [31:0] held = '0;
      logic        err_next;
      build_expected();
      n_done = 0;
      err_model = 1'b0;
      @(negedge clk);
      start = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      check("busy_after_start", 32'(busy), 32'd1);
      check("err_after_start", 32'(err), 32'd0);
      while (wi < WORDS && cyc < 3000) begin
         @(negedge clk);
         in_valid  = (ci < N);
         in_data   = (in_valid && in_ready) ? coefs[ci] : 32'hDEADBEEF;
         out_ready = !(out_valid && wi == stall_word && stall_left > 0);
         #1;
         err_next = err_model;
         check("excl_ready_valid", 32'(in_ready && out_valid), 32'd0);
         check("err", 32'(err), 32'(err_model));
         if (done) n_done++;
         if (out_valid && first_ov < 0) first_ov = cyc;
         if (out_valid && !out_ready) begin
            if (stall_left == stall_cyc) held = out_data;
            else check("stall_hold", out_data, held);
            check("stall_in_ready", 32'(in_ready), 32'd0);
            stall_left--;
         end
         if (out_valid && out_ready) begin
            got[wi] = out_data;
            check($sformatf("word%0d", wi), out_data, exp_bits[wi*32 +: 32]);
            wi++;
         end
         if (in_valid && in_ready) begin
            if (hs0 < 0) hs0 = cyc;
`ifdef RANGE_CHECK_EN
            if ($signed(coefs[ci]) < -4095 || $signed(coefs[ci]) > 4096) err_next = 1'b1;
`endif
            ci++;
         end
         err_model = err_next;
         cyc++;
         if (abort_after >= 0 && ci >= abort_after) break;
      end
      if (abort_after < 0) begin
         check("word_count", 32'(wi), 32'(WORDS));
         check("coef_count", 32'(ci), 32'(N));
         check("latency", 32'(first_ov - hs0), 32'd3);
         @(negedge clk);
         in_valid = 1'b0;
         check("done_pulse", 32'(done), 32'd1);
         check("busy_at_done", 32'(busy), 32'd0);
         if (done) n_done++;
         repeat (4) begin
            @(negedge clk);
            if (done) n_done++;
         end
         check("done_once", 32'(n_done), 32'd1);
         check("idle_out_valid", 32'(out_valid), 32'd0);
         check("err_sticky", 32'(err), 32'(err_model));
      end
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
      repeat (3) @(negedge clk);
      check_idle_reset();
      rst = 1'b0;

      // All zero coefficients
      fill_coefs(32'd0);
      run_poly(-1, 0, -1);
      check("a0_word0", got[0], 32'h02001000);
      check("a0_word1", got[1], 32'h00080040);

      // a = 4096 packs to all zeros
      fill_coefs(32'd4096);
      run_poly(-1, 0, -1);
      for (int w = 0; w < WORDS; w++) check("a4096_word", got[w], 32'h00000000);

      // a = -4095 packs to all ones
      fill_coefs(-32'sd4095);
      run_poly(-1, 0, -1);
      for (int w = 0; w < WORDS; w++) check("am4095_word", got[w], 32'hFFFFFFFF);

      // Ramp with a mid-stream stall
      for (int k = 0; k < N; k++) coefs[k] = 32'(k - 128);
      run_poly(5, 3, -1);

      // Stall the very first word for 5 cycles
      fill_coefs(32'd0);
      run_poly(0, 5, -1);
      check("stall_word0", got[0], 32'h02001000);

      // Abort after 40 coefficients, then a clean run
      fill_coefs(32'd0);
      run_poly(-1, 0, 40);
      @(negedge clk);
      rst = 1'b1; start = 1'b1; in_valid = 1'b0;
      @(negedge clk);
      rst = 1'b0; start = 1'b0;
      check_idle_reset();
      n_done = 0;
      repeat (5) begin
         @(negedge clk);
         if (done) n_done++;
      end
      check("abort_no_done", 32'(n_done), 32'd0);
      check("abort_idle", 32'(busy), 32'd0);
      run_poly(-1, 0, -1);
      check("post_abort_word0", got[0], 32'h02001000);
      check("post_abort_word1", got[1], 32'h00080040);

`ifdef RANGE_CHECK_EN
      fill_coefs(32'd0);
      coefs[7] = 32'd5000;
      run_poly(-1, 0, -1);
      check("range_err_set", 32'(err), 32'd1);
      fill_coefs(32'd0);
      run_poly(-1, 0, -1);
      check("range_err_cleared", 32'(err), 32'd0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
